// File: rtl/alu_issue_ctrl.sv
// Round-robin issue scheduler for the shared Stage2 ALU with credit-protected, in-order response FIFO.
// Optional perf counters (perf_issued/perf_stall) are built when ALU_ISSUE_PERF_EN is defined.
module alu_issue_ctrl #(
  parameter int N     = 32,
  parameter int O     = 3,
  parameter int S     = 5,
  parameter int NREQ  = 2,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_kind,
  input  logic [NREQ*N-1:0]        req_aluin1,
  input  logic [NREQ*N-1:0]        req_aluin2,
  input  logic [NREQ*O-1:0]        req_operation,
  input  logic [NREQ*O-1:0]        req_opselect,
  input  logic [NREQ*S-1:0]        req_shamt,
  output logic [N-1:0]             aluin1,
  output logic [N-1:0]             aluin2,
  output logic [O-1:0]             operation,
  output logic [O-1:0]             opselect,
  output logic [S-1:0]             shift_number,
  output logic                     enable_arith,
  output logic                     enable_shift,
  input  logic [N-1:0]             alu_out,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [N-1:0]             rsp_data,
  output logic                     rsp_carry
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]              perf_issued,
  output logic [31:0]              perf_stall
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] rr_q, rr_d, gid;
  logic [IDW:0]   sum;
  logic [NREQ-1:0] grant;
  logic            accept, credit_ok;
  logic [CW-1:0]   infl;
  logic [N-1:0]    sel_a1, sel_a2;
  logic [O-1:0]    sel_op, sel_os;
  logic [S-1:0]    sel_sh;
  logic            sel_kind;

  logic [LAT:0]    pv_q;
  logic [IDW-1:0]  pid_q [LAT+1];

  logic [IDW-1:0]  fid_q   [DEPTH];
  logic [N-1:0]    fdata_q [DEPTH];
  logic            fcar_q  [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            push, pop;

  // Ops between accept and FIFO push hold a credit just like queued responses.
  always_comb begin
    infl = '0;
    for (int i = 0; i <= LAT; i++) infl = infl + CW'(pv_q[i]);
    credit_ok = ({1'b0, cnt_q} + {1'b0, infl}) < (CW+1)'(DEPTH);
  end

  always_comb begin
    grant = '0;
    gid   = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (grant == '0 && req_valid[sum[IDW-1:0]]) begin
        grant[sum[IDW-1:0]] = 1'b1;
        gid                 = sum[IDW-1:0];
      end
    end
    if (!credit_ok || !reset) begin
      grant = '0;
      gid   = '0;
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign rr_d      = (gid == IDW'(NREQ-1)) ? '0 : gid + IDW'(1);

  always_comb begin
    sel_a1   = '0;
    sel_a2   = '0;
    sel_op   = '0;
    sel_os   = '0;
    sel_sh   = '0;
    sel_kind = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a1   = req_aluin1[i*N +: N];
        sel_a2   = req_aluin2[i*N +: N];
        sel_op   = req_operation[i*O +: O];
        sel_os   = req_opselect[i*O +: O];
        sel_sh   = req_shamt[i*S +: S];
        sel_kind = req_kind[i];
      end
    end
  end

  // Issue stage: ALU bus, enable pulse and in-flight tag pipe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q         <= '0;
      aluin1       <= '0;
      aluin2       <= '0;
      operation    <= '0;
      opselect     <= '0;
      shift_number <= '0;
      enable_arith <= 1'b0;
      enable_shift <= 1'b0;
      pv_q         <= '0;
      for (int i = 0; i <= LAT; i++) pid_q[i] <= '0;
    end else begin
      enable_arith <= accept & ~sel_kind;
      enable_shift <= accept & sel_kind;
      pv_q         <= {pv_q[LAT-1:0], accept};
      pid_q[0]     <= gid;
      for (int i = 1; i <= LAT; i++) pid_q[i] <= pid_q[i-1];
      if (accept) begin
        rr_q         <= rr_d;
        aluin1       <= sel_a1;
        aluin2       <= sel_a2;
        operation    <= sel_op;
        opselect     <= sel_os;
        shift_number <= sel_sh;
      end
    end
  end

  assign push = pv_q[LAT];
  assign pop  = rsp_valid & rsp_ready;

  // Response stage: show-ahead FIFO, result captured as the tag leaves the pipe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fid_q[i]   <= '0;
        fdata_q[i] <= '0;
        fcar_q[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        fid_q[wr_q]   <= pid_q[LAT];
        fdata_q[wr_q] <= alu_out;
        fcar_q[wr_q]  <= alu_carry;
        wr_q          <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign rsp_valid = (cnt_q != '0);
  assign rsp_id    = fid_q[rd_q];
  assign rsp_data  = fdata_q[rd_q];
  assign rsp_carry = fcar_q[rd_q];

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
      if ((|req_valid) && !accept && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl; includes a one-cycle-latency ALU model.
module tb_alu_issue_ctrl;
  localparam int N = 32, O = 3, S = 5, NREQ = 2, LAT = 1, DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0, req_kind = '0, req_ready;
  logic [NREQ*N-1:0] req_aluin1 = '0, req_aluin2 = '0;
  logic [NREQ*O-1:0] req_operation = '0, req_opselect = '0;
  logic [NREQ*S-1:0] req_shamt = '0;
  logic [N-1:0] aluin1, aluin2, rsp_data;
  logic [O-1:0] operation, opselect;
  logic [S-1:0] shift_number;
  logic enable_arith, enable_shift, rsp_valid, rsp_carry;
  logic [N-1:0] alu_out = '0;
  logic alu_carry = 1'b0;
  logic rsp_ready = 1'b0;
  logic [$clog2(NREQ)-1:0] rsp_id;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.N(N), .O(O), .S(S), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_aluin1(req_aluin1), .req_aluin2(req_aluin2),
    .req_operation(req_operation), .req_opselect(req_opselect), .req_shamt(req_shamt),
    .aluin1(aluin1), .aluin2(aluin2), .operation(operation), .opselect(opselect),
    .shift_number(shift_number), .enable_arith(enable_arith), .enable_shift(enable_shift),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clock = ~clock;

  // ALU: add (with carry) or left shift, result valid the cycle after the enable pulse.
  logic cap_a = 1'b0, cap_s = 1'b0;
  logic [N-1:0] c1 = '0, c2 = '0;
  logic [S-1:0] csh = '0;
  always @(negedge clock) begin
    cap_a = enable_arith;
    cap_s = enable_shift;
    c1 = aluin1;
    c2 = aluin2;
    csh = shift_number;
  end
  always @(posedge clock) begin
    #2;
    if (cap_a === 1'b1) {alu_carry, alu_out} = {1'b0, c1} + {1'b0, c2};
    else if (cap_s === 1'b1) begin
      alu_out = c1 << csh;
      alu_carry = 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b expected 00", req_ready); end
    checks++; if (enable_arith !== 1'b0 || enable_shift !== 1'b0) begin errors++; $display("FAIL rst_enables: got %b%b expected 00", enable_arith, enable_shift); end
    checks++; if (aluin1 !== '0 || aluin2 !== '0 || shift_number !== '0) begin errors++; $display("FAIL rst_bus: got %0h %0h %0h expected 0", aluin1, aluin2, shift_number); end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL rst_rsp: got v=%b d=%0h id=%0d expected 0", rsp_valid, rsp_data, rsp_id); end
    req_valid = '0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_single_arith();
    do_reset();
    req_kind = 2'b00;
    req_aluin1 = {32'd0, 32'd5};
    req_aluin2 = {32'd0, 32'd3};
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t1_grant: got %b expected 01", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if (enable_arith !== 1'b1 || enable_shift !== 1'b0) begin errors++; $display("FAIL t1_pulse: got a=%b s=%b expected a=1 s=0", enable_arith, enable_shift); end
    checks++; if (aluin1 !== 32'd5 || aluin2 !== 32'd3) begin errors++; $display("FAIL t1_bus: got %0d %0d expected 5 3", aluin1, aluin2); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_early_rsp: got %b expected 0", rsp_valid); end
    step();
    checks++; if (enable_arith !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_pulse_end: got a=%b v=%b expected 0 0", enable_arith, rsp_valid); end
    checks++; if (aluin1 !== 32'd5) begin errors++; $display("FAIL t1_bus_hold: got %0d expected 5", aluin1); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd8 || rsp_carry !== 1'b0) begin errors++; $display("FAIL t1_rsp: got v=%b id=%0d d=%0d c=%b expected 1 0 8 0", rsp_valid, rsp_id, rsp_data, rsp_carry); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_pop: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy;
    logic [N-1:0] exp_d;
    do_reset();
    req_kind = 2'b00;
    req_aluin1 = {32'hFFFF_FFFF, 32'd10};
    req_aluin2 = {32'd2, 32'd20};
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL t2_grant%0d: got %b expected %b", i, req_ready, exp_rdy); end
      step();
    end
    req_valid = 2'b00;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      exp_d = (i % 2 == 0) ? 32'd30 : 32'd1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_data !== exp_d || rsp_carry !== 1'(i % 2)) begin
        errors++;
        $display("FAIL t2_rsp%0d: got v=%b id=%0d d=%0h c=%b expected 1 %0d %0h %0d", i, rsp_valid, rsp_id, rsp_data, rsp_carry, i % 2, exp_d, i % 2);
      end
      rsp_ready = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t2_drained: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_shift();
    do_reset();
    req_kind = 2'b10;
    req_aluin1 = {32'h1, 32'h0};
    req_aluin2 = '0;
    req_shamt = {5'd4, 5'd0};
    rsp_ready = 1'b1;
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL t3_grant: got %b expected 10", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if (enable_shift !== 1'b1 || enable_arith !== 1'b0) begin errors++; $display("FAIL t3_pulse: got s=%b a=%b expected s=1 a=0", enable_shift, enable_arith); end
    checks++; if (shift_number !== 5'd4 || aluin1 !== 32'h1) begin errors++; $display("FAIL t3_bus: got sh=%0d a1=%0h expected 4 1", shift_number, aluin1); end
    step();
    checks++; if (enable_shift !== 1'b0 || enable_arith !== 1'b0) begin errors++; $display("FAIL t3_pulse_end: got s=%b a=%b expected 0 0", enable_shift, enable_arith); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd16) begin errors++; $display("FAIL t3_rsp: got v=%b id=%0d d=%0d expected 1 1 16", rsp_valid, rsp_id, rsp_data); end
    step();
    req_kind = 2'b00;
  endtask

  task automatic test_credit_stall();
    int acc;
    do_reset();
    req_kind = 2'b00;
    req_aluin1 = {32'd7, 32'd1};
    req_aluin2 = {32'd7, 32'd1};
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    #1;
    acc = 0;
    repeat (8) begin
      acc += $countones(req_valid & req_ready);
      step();
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL t4_accepts: got %0d expected 4", acc); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL t4_stalled: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd2 || rsp_id !== 1'b0) begin errors++; $display("FAIL t4_head: got v=%b d=%0d id=%0d expected 1 2 0", rsp_valid, rsp_data, rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    acc = 0;
    repeat (6) begin
      acc += $countones(req_valid & req_ready);
      step();
    end
    checks++; if (acc != 1) begin errors++; $display("FAIL t4_resume: got %0d expected 1", acc); end
    checks++; if (rsp_id !== 1'b1 || rsp_data !== 32'd14) begin errors++; $display("FAIL t4_head2: got id=%0d d=%0d expected 1 14", rsp_id, rsp_data); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    req_kind = 2'b00;
    req_aluin1 = {32'd9, 32'd4};
    req_aluin2 = {32'd9, 32'd4};
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++; if (enable_arith !== 1'b0 || enable_shift !== 1'b0) begin errors++; $display("FAIL t5_enables: got %b%b expected 00", enable_arith, enable_shift); end
    checks++; if (aluin1 !== '0 || aluin2 !== '0) begin errors++; $display("FAIL t5_bus: got %0h %0h expected 0 0", aluin1, aluin2); end
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_data !== '0) begin errors++; $display("FAIL t5_outs: got r=%b v=%b d=%0h expected 00 0 0", req_ready, rsp_valid, rsp_data); end
    req_valid = 2'b00;
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t5_stale%0d: got %b expected 0", i, rsp_valid); end
    end
  endtask

`ifdef ALU_ISSUE_PERF_EN
  task automatic test_perf();
    do_reset();
    req_kind = 2'b00;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    repeat (7) step();
    req_valid = 2'b00;
    repeat (3) step();
    rsp_ready = 1'b1;
    repeat (4) step();
    req_valid = 2'b01;
    repeat (6) step();
    req_valid = 2'b00;
    repeat (4) step();
    checks++; if (perf_issued !== 32'd10) begin errors++; $display("FAIL t6_issued: got %0d expected 10", perf_issued); end
    checks++; if (perf_stall !== 32'd3) begin errors++; $display("FAIL t6_stall: got %0d expected 3", perf_stall); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_arith();
    test_back_to_back();
    test_shift();
    test_credit_stall();
    test_reset_inflight();
`ifdef ALU_ISSUE_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
